// File: rtl/dog_extrema.sv
`default_nettype none
// ======================================================================
// dog_extrema : 3x3 local-extremum (keypoint) detector on a raster DoG stream
// Optional feature macro: DOG_EXTREMA_MIN_EN (also report local minima)
// Revision: 1.0
// ======================================================================
module dog_extrema #(
  parameter int W      = 8,
  parameter int H      = 8,
  parameter int THRESH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        sof,
  output logic        kp_valid,
  output logic [7:0]  kp_x,
  output logic [7:0]  kp_y,
  output logic [15:0] kp_val,
  output logic        kp_type,
  output logic        frame_done,
  output logic        busy
);

  localparam int                 AW      = $clog2(W);
  localparam logic [7:0]         C_XMAX  = 8'(W - 1);
  localparam logic [7:0]         C_YMAX  = 8'(H - 1);
  localparam logic signed [15:0] C_THR_P = 16'(THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         x_q, y_q, x_d, y_d;
  logic [7:0]         px, py;
  logic signed [15:0] win_q [3][3];
  logic [15:0]        lb0_q [W];
  logic [15:0]        lb1_q [W];
  logic signed [15:0] col [3];
  logic signed [15:0] ctr;
  logic               accept, complete, last_beat, is_max, hit;
  logic               kp_valid_q, frame_done_q;
  logic [7:0]         kp_x_q, kp_y_q;
  logic [15:0]        kp_val_q;

  // A sof beat is always pixel (0,0), whatever the counters currently say.
  assign accept    = din_valid && (sof || (state_q != IDLE));
  assign px        = sof ? 8'd0 : x_q;
  assign py        = sof ? 8'd0 : y_q;
  assign complete  = accept && (px >= 8'd2) && (py >= 8'd2);
  assign last_beat = (state_q == SCAN) && (px == C_XMAX) && (py == C_YMAX);

  assign col[0] = lb1_q[px[AW-1:0]];
  assign col[1] = lb0_q[px[AW-1:0]];
  assign col[2] = din;
  assign ctr    = win_q[1][2];

  always_comb begin
    x_d = px + 8'd1;
    y_d = py;
    if (px == C_XMAX) begin
      x_d = 8'd0;
      y_d = py + 8'd1;
    end
  end

  // Neighbours: column x-2 in win_q[*][1], column x-1 above/below centre, column x incoming.
  always_comb begin
    is_max = (ctr > C_THR_P);
    for (int r = 0; r < 3; r++) begin
      if (!(ctr > win_q[r][1])) is_max = 1'b0;
      if (!(ctr > col[r]))      is_max = 1'b0;
      if ((r != 1) && !(ctr > win_q[r][2])) is_max = 1'b0;
    end
  end

`ifdef DOG_EXTREMA_MIN_EN
  localparam logic signed [15:0] C_THR_N = -C_THR_P;
  logic is_min;
  logic kp_type_q;

  always_comb begin
    is_min = (ctr < C_THR_N);
    for (int r = 0; r < 3; r++) begin
      if (!(ctr < win_q[r][1])) is_min = 1'b0;
      if (!(ctr < col[r]))      is_min = 1'b0;
      if ((r != 1) && !(ctr < win_q[r][2])) is_min = 1'b0;
    end
  end

  assign hit     = is_max || is_min;
  assign kp_type = kp_type_q;
`else
  assign hit     = is_max;
  assign kp_type = 1'b1;
`endif

  // Line buffers hold rows y-1 (lb0) and y-2 (lb1); contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[px[AW-1:0]] <= lb0_q[px[AW-1:0]];
      lb0_q[px[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= 16'sd0;
      end
      kp_valid_q   <= 1'b0;
      kp_x_q       <= 8'd0;
      kp_y_q       <= 8'd0;
      kp_val_q     <= 16'd0;
      frame_done_q <= 1'b0;
`ifdef DOG_EXTREMA_MIN_EN
      kp_type_q    <= 1'b0;
`endif
    end else begin
      kp_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= col[r];
        end
        x_q <= x_d;
        y_q <= y_d;
        if (sof) begin
          state_q <= FILL;
        end else if ((state_q == FILL) && (px == C_XMAX) && (py == 8'd1)) begin
          state_q <= SCAN;
        end else if (last_beat) begin
          state_q      <= IDLE;
          x_q          <= 8'd0;
          y_q          <= 8'd0;
          frame_done_q <= 1'b1;
        end
        if (complete && hit) begin
          kp_valid_q <= 1'b1;
          kp_x_q     <= px - 8'd1;
          kp_y_q     <= py - 8'd1;
          kp_val_q   <= ctr;
`ifdef DOG_EXTREMA_MIN_EN
          kp_type_q  <= is_max;
`endif
        end
      end
    end
  end

  assign kp_valid   = kp_valid_q;
  assign kp_x       = kp_x_q;
  assign kp_y       = kp_y_q;
  assign kp_val     = kp_val_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema.sv
`default_nettype none
// tb_dog_extrema : directed + randomized frames checked against a frame-level keypoint model.
module tb_dog_extrema;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int THRESH = 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        din_valid = 1'b0;
  logic        sof       = 1'b0;
  logic [15:0] din       = 16'd0;
  logic        kp_valid, kp_type, frame_done, busy;
  logic [7:0]  kp_x, kp_y;
  logic [15:0] kp_val;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] img [H][W];
  logic [7:0]  last_kx, last_ky;
  logic [15:0] last_kv;
  logic        last_kt;

  dog_extrema #(.W(W), .H(H), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sof       (sof),
    .kp_valid  (kp_valid),
    .kp_x      (kp_x),
    .kp_y      (kp_y),
    .kp_val    (kp_val),
    .kp_type   (kp_type),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [15:0] d, input bit r);
    din_valid = v;
    sof       = s;
    din       = d;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input bit ekv, input bit efd, input bit ebusy);
    chk("kp_valid",   32'(kp_valid),   32'(ekv));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("busy",       32'(busy),       32'(ebusy));
    chk("kp_x",       32'(kp_x),       32'(last_kx));
    chk("kp_y",       32'(kp_y),       32'(last_ky));
    chk("kp_val",     32'(kp_val),     32'(last_kv));
    chk("kp_type",    32'(kp_type),    32'(last_kt));
  endtask

  task automatic clear_model_kp();
    last_kx = 8'd0;
    last_ky = 8'd0;
    last_kv = 16'd0;
`ifdef DOG_EXTREMA_MIN_EN
    last_kt = 1'b0;
`else
    last_kt = 1'b1;
`endif
  endtask

  // 1 = maximum, 0 = minimum, -1 = not a keypoint
  function automatic int kp_kind(int cx, int cy);
    int  c;
    bit  gt;
    c  = int'(img[cy][cx]);
    gt = 1'b1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && !(c > int'(img[cy+dy][cx+dx]))) gt = 1'b0;
    if (gt && (c > THRESH)) return 1;
`ifdef DOG_EXTREMA_MIN_EN
    begin
      bit lt;
      lt = 1'b1;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if ((dx != 0 || dy != 0) && !(c < int'(img[cy+dy][cx+dx]))) lt = 1'b0;
      if (lt && (c < -THRESH)) return 0;
    end
`endif
    return -1;
  endfunction

  function automatic logic signed [15:0] rnd_val();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 16'sh7FFF;
    if (r == 1) return 16'sh8000;
    return 16'(int'($urandom_range(0, 240)) - 120);
  endfunction

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 16'sd0;
  endtask

  task automatic rand_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = rnd_val();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    clear_model_kp();
    check_outs(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 16'hDEAD, 1'b1);
      check_outs(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic ignored(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'd100, 1'b1);
      check_outs(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Sends beats 0..nbeats-1 of img; beat 0 carries sof.
  task automatic send_frame(input int nbeats, input bit gaps);
    for (int n = 0; n < nbeats; n++) begin
      int x, y, k, g;
      x = n % W;
      y = n / W;
      if (gaps && n > 0) begin
        g = int'($urandom_range(0, 2));
        for (int i = 0; i < g; i++) begin
          step(1'b0, 1'b0, 16'(int'($urandom)), 1'b1);
          check_outs(1'b0, 1'b0, 1'b1);
        end
      end
      step(1'b1, (n == 0), img[y][x], 1'b1);
      k = (x >= 2 && y >= 2) ? kp_kind(x - 1, y - 1) : -1;
      if (k >= 0) begin
        last_kx = 8'(x - 1);
        last_ky = 8'(y - 1);
        last_kv = img[y-1][x-1];
`ifdef DOG_EXTREMA_MIN_EN
        last_kt = (k == 1);
`endif
      end
      check_outs((k >= 0), (n == W*H - 1), (n != W*H - 1));
    end
  endtask

  initial begin
    do_reset(2);
    ignored(3);

    // all-zero frame
    clear_img();
    send_frame(W*H, 1'b0);
    idle(2);

    // single peak of 100 at (3,4)
    clear_img();
    img[4][3] = 16'sd100;
    send_frame(W*H, 1'b0);
    chk("peak_x",   32'(kp_x),   32'd3);
    chk("peak_y",   32'(kp_y),   32'd4);
    chk("peak_val", 32'(kp_val), 32'd100);

    // single trough of -100 at (2,2)
    clear_img();
    img[2][2] = -16'sd100;
    send_frame(W*H, 1'b0);
`ifdef DOG_EXTREMA_MIN_EN
    chk("trough_val",  32'(kp_val),  32'h0000FF9C);
    chk("trough_type", 32'(kp_type), 32'd0);
`else
    chk("trough_ignored_val", 32'(kp_val), 32'd100);
`endif

    // threshold boundary, ties and border
    clear_img();
    img[3][3] = 16'sd16;
    send_frame(W*H, 1'b0);
    clear_img();
    img[3][3] = 16'sd17;
    send_frame(W*H, 1'b0);
    clear_img();
    img[3][3] = 16'sd50;
    img[3][4] = 16'sd50;
    send_frame(W*H, 1'b0);
    clear_img();
    img[3][0] = 16'sd100;
    send_frame(W*H, 1'b0);

    // peak frame with random valid gaps
    clear_img();
    img[4][3] = 16'sd100;
    send_frame(W*H, 1'b1);
    chk("gap_peak_x", 32'(kp_x), 32'd3);
    chk("gap_peak_y", 32'(kp_y), 32'd4);

    // random frames
    for (int f = 0; f < 6; f++) begin
      rand_img();
      send_frame(W*H, (f % 2) == 1);
    end

    // sof restart after 20 beats
    rand_img();
    send_frame(20, 1'b1);
    rand_img();
    send_frame(W*H, 1'b1);
    idle(2);

    // reset at beat 30
    rand_img();
    send_frame(30, 1'b0);
    step(1'b1, 1'b0, img[3][6], 1'b0);
    clear_model_kp();
    check_outs(1'b0, 1'b0, 1'b0);
    ignored(5);
    rand_img();
    send_frame(W*H, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dog_extrema.md
DOG_EXTREMA -- requirements
Module: dog_extrema

Interface
REQ-001 Parameter W, default 8, image width in samples; 3..255.
REQ-002 Parameter H, default 8, image height in rows; 3..255.
REQ-003 Parameter THRESH, default 16, unsigned contrast threshold, 15 bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 din  input  16  DoG sample, two's-complement signed, raster order.
REQ-007 din_valid  input  1  din is a valid sample this cycle.
REQ-008 sof  input  1  start of frame; qualified by din_valid; marks pixel (0,0).
REQ-009 kp_valid  output  1  one-cycle pulse: keypoint fields valid.
REQ-010 kp_x  output  8  keypoint column.
REQ-011 kp_y  output  8  keypoint row.
REQ-012 kp_val  output  16  keypoint DoG value, signed.
REQ-013 kp_type  output  1  1 = local maximum, 0 = local minimum.
REQ-014 frame_done  output  1  one-cycle pulse after the last sample of a frame.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL hold two W-entry line buffers and a 3x3 window of 16-bit signed registers, advanced only on din_valid beats.
REQ-017 The FSM SHALL have three states, IDLE, FILL and SCAN, with these transitions:
- IDLE->FILL on din_valid&sof.
- FILL->SCAN on the beat at (x=W-1, y=1).
- SCAN->IDLE on the beat at (x=W-1, y=H-1).
REQ-018 While in IDLE, valid beats without sof SHALL be ignored.
REQ-019 Column and row counters SHALL increment on each accepted beat; x SHALL wrap at W-1 to 0 and increment y.
REQ-020 A beat at (x,y) with x>=2 and y>=2 SHALL complete the window centred at (x-1,y-1); border pixels SHALL never be keypoints.
REQ-021 The centre value C SHALL be a maximum when both hold:
- C is strictly greater than all 8 neighbours.
- C > +THRESH (signed compare).
REQ-022 The centre value C SHALL be a minimum when both hold:
- C is strictly less than all 8 neighbours.
- C < -THRESH (signed compare).
REQ-023 kp_valid SHALL be registered and rise exactly one clock after the completing beat, carrying kp_x=x-1, kp_y=y-1, kp_val=C and kp_type.
REQ-024 kp_x, kp_y, kp_val and kp_type SHALL hold their last values while kp_valid is low.
REQ-025 frame_done SHALL pulse one clock after the final beat of the frame, in the same cycle as any final kp_valid.
REQ-026 Gaps in din_valid SHALL stall all state: no output and no counter change.
REQ-027 sof with din_valid in FILL or SCAN SHALL abandon the current frame without a frame_done pulse:
- Counters restart with that beat as (0,0).
- The state becomes FILL.
- Line-buffer contents are treated as invalid until refilled.
REQ-028 All comparisons SHALL be full 16-bit signed, with no saturation or truncation.

Reset
REQ-029 While rst=0 at a clock edge, the state SHALL be IDLE and the counters, window registers, kp_valid, kp_x, kp_y, kp_val, kp_type, frame_done and busy SHALL all be 0.
REQ-030 Line-buffer RAM contents SHALL not require reset.
REQ-031 A reset asserted mid-frame SHALL discard the frame; the next frame SHALL begin only on sof.

Configuration
REQ-032 With DOG_EXTREMA_MIN_EN defined, minima SHALL be detected per REQ-022.
REQ-033 Without DOG_EXTREMA_MIN_EN, only maxima SHALL be reported, kp_type SHALL be constant 1, and the minimum comparators SHALL not be built.

Verification
REQ-034 All-zero 8x8 frame -> no kp_valid; exactly one frame_done, one clock after beat 64; busy low afterwards.
REQ-035 8x8 frame, zeros except 100 at (3,4) -> exactly one kp_valid, one clock after beat (4,5), with kp_x=3, kp_y=4, kp_val=100, kp_type=1.
REQ-036 Zeros except -100 at (2,2) -> with the macro, one kp_valid with kp_type=0 and kp_val=-100 (0xFF9C); without the macro, no kp_valid.
REQ-037 Boundary values:
- 16 at (3,3) -> no keypoint (not > THRESH).
- 50 at both (3,3) and (4,3) -> no keypoint (not strict).
- 100 at (0,3) -> no keypoint (border).
REQ-038 Stall and restart:
- Random din_valid gaps on the REQ-035 frame -> identical keypoint output.
- sof after 20 beats -> no frame_done for the first frame; frame_done one clock after 64 further beats.
REQ-039 rst=0 for one cycle at beat 30 -> all outputs 0 on the next cycle; non-sof beats ignored until sof arrives.
